// File: rtl/tone_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tone_i2s_tx
// Brief    : Stereo square-wave tone synthesizer with a left-justified
//            4-wire serial DAC link (mclk, lrck, sck, sdin).
// Revision : 1.0 - initial release
// ============================================================================
module tone_i2s_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int SIL_HZ = 20_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
    input  logic [2:0]  volume,
    input  logic        mute,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_div_l = 2'd1;
    localparam logic [1:0]  c_st_div_r = 2'd2;
    localparam logic [31:0] c_dividend = 32'(CLK_HZ);
    localparam logic [31:0] c_sil      = 32'(SIL_HZ);
    localparam logic [5:0]  c_div_last = 6'd32;

    logic [1:0]  r_state;
    logic [5:0]  r_dcnt;
    logic [31:0] r_capL;
    logic [31:0] r_capR;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_hp    [2];
    logic [31:0] r_tcnt  [2];
    logic        r_phase [2];
    logic [8:0]  r_fc;
    logic [15:0] r_frame_l;
    logic [15:0] r_frame_r;
    logic        r_sdin;

    logic [31:0] w_cap;
    logic        w_silent;
    logic [32:0] w_divisor;
    logic [33:0] w_shift;
    logic [33:0] w_trial;
    logic        w_ge;
    logic        w_div_done;
    logic [31:0] w_hp_new;
    logic [1:0]  w_ld;
    logic        w_unused;
    logic [15:0] w_amp;
    logic [15:0] w_smp [2];
    logic [8:0]  w_fc_nx;
    logic        w_wrap;
    logic [15:0] w_word;
    logic [3:0]  w_bit_idx;

    // Restoring division of CLK_HZ by 2*tone, one quotient bit per cycle.
    assign w_cap      = (r_state == c_st_div_r) ? r_capR : r_capL;
    assign w_silent   = (w_cap == 32'd0) || (w_cap >= c_sil);
    assign w_divisor  = {w_cap, 1'b0};
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, w_divisor});
    assign w_trial    = w_shift - {1'b0, w_divisor};
    assign w_div_done = (r_state != c_st_idle) &&
                        (((r_dcnt == 6'd0) && w_silent) || (r_dcnt == c_div_last));
    assign w_hp_new   = w_silent ? 32'd0 : r_quo;
    assign w_ld[0]    = w_div_done && (r_state == c_st_div_l);
    assign w_ld[1]    = w_div_done && (r_state == c_st_div_r);
    assign w_unused   = &{1'b0, w_trial[33], w_shift[33]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_dcnt  <= 6'd0;
            r_capL  <= 32'd0;
            r_capR  <= 32'd0;
            r_rem   <= 33'd0;
            r_quo   <= 32'd0;
            r_hp[0] <= 32'd0;
            r_hp[1] <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_dcnt <= 6'd0;
                    r_rem  <= 33'd0;
                    r_quo  <= c_dividend;
                    if (toneL != r_capL) begin
                        r_capL  <= toneL;
                        r_state <= c_st_div_l;
                    end else if (toneR != r_capR) begin
                        r_capR  <= toneR;
                        r_state <= c_st_div_r;
                    end
                end
                c_st_div_l, c_st_div_r: begin
                    if (w_div_done) begin
                        if (r_state == c_st_div_r) begin
                            r_hp[1] <= w_hp_new;
                        end else begin
                            r_hp[0] <= w_hp_new;
                        end
                        r_state <= c_st_idle;
                    end else begin
                        r_rem  <= w_ge ? w_trial[32:0] : w_shift[32:0];
                        r_quo  <= {r_quo[30:0], w_ge};
                        r_dcnt <= r_dcnt + 6'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Half-period counters; a freshly loaded hp restarts the count but keeps phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_tcnt[i]  <= 32'd0;
                r_phase[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_ld[i] || (r_hp[i] == 32'd0)) begin
                    r_tcnt[i] <= 32'd0;
                end else if (r_tcnt[i] == r_hp[i] - 32'd1) begin
                    r_tcnt[i]  <= 32'd0;
                    r_phase[i] <= ~r_phase[i];
                end else begin
                    r_tcnt[i] <= r_tcnt[i] + 32'd1;
                end
            end
        end
    end

    assign w_amp = (volume >= 3'd5) ? 16'h4000 : (16'h0200 << volume);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_smp[i] = 16'h0000;
            if (!mute && (r_hp[i] != 32'd0)) begin
                w_smp[i] = r_phase[i] ? w_amp : (~w_amp + 16'd1);
            end
        end
    end

    // The word for the next bit slot is chosen from the post-increment counter,
    // so the new left sample's MSB leaves on the same edge the frame is latched.
    assign w_fc_nx   = r_fc + 9'd1;
    assign w_wrap    = (r_fc == 9'd511);
    assign w_word    = w_fc_nx[8] ? r_frame_r : (w_wrap ? w_smp[0] : r_frame_l);
    assign w_bit_idx = 4'd15 - w_fc_nx[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc      <= 9'd0;
            r_frame_l <= 16'd0;
            r_frame_r <= 16'd0;
            r_sdin    <= 1'b0;
        end else begin
            r_fc <= w_fc_nx;
            if (w_wrap) begin
                r_frame_l <= w_smp[0];
                r_frame_r <= w_smp[1];
            end
            if (r_fc[3:0] == 4'hF) begin
                r_sdin <= w_word[w_bit_idx];
            end
        end
    end

    assign audio_mclk = r_fc[1];
    assign audio_sck  = r_fc[3];
    assign audio_lrck = r_fc[8];
    assign audio_sdin = r_sdin;

endmodule
`default_nettype wire

// File: tb/tb_tone_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_i2s_tx
// Brief    : Scoreboard bench for tone_i2s_tx: divider timing, frame content,
//            link framing, mute/volume and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] toneL = 32'd0;
    logic [31:0] toneR = 32'd0;
    logic [2:0]  volume = 3'd0;
    logic        mute = 1'b0;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] la;
        logic [15:0] lb;
        logic [15:0] ra;
        logic [15:0] rb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] wl;
    logic [15:0] wr;
    logic [8:0]  fcb;

    tone_i2s_tx #(
        .CLK_HZ(100_000_000),
        .SIL_HZ(20_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .toneL      (toneL),
        .toneR      (toneR),
        .volume     (volume),
        .mute       (mute),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    // Reference frame position, restarted by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) fcb <= 9'd0;
        else     fcb <= fcb + 9'd1;
    end

    // Deserialize mid-bit; pop one expectation per completed frame.
    always @(negedge clk) begin
        if (!rst && fcb[3:0] == 4'd8) begin
            if (!fcb[8]) wl[4'd15 - fcb[7:4]] = audio_sdin;
            else         wr[4'd15 - fcb[7:4]] = audio_sdin;
            if (fcb == 9'd504 && sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                if (!(wl === mon_e.la || wl === mon_e.lb)) begin
                    failures++;
                    $display("FAIL frame_left got=%h want=%h|%h", wl, mon_e.la, mon_e.lb);
                end
                checks++;
                if (!(wr === mon_e.ra || wr === mon_e.rb)) begin
                    failures++;
                    $display("FAIL frame_right got=%h want=%h|%h", wr, mon_e.ra, mon_e.rb);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_fc(input logic [8:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fcb !== v && n < 1100);
        if (fcb !== v) begin
            checks++;
            failures++;
            $display("FAIL wait_fc got=%0d want=%0d", fcb, v);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic set_tones(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        toneL = l;
        toneR = r;
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.la = a; e.lb = b; e.ra = a; e.rb = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {audio_mclk, audio_sck, audio_lrck, audio_sdin});
        end
        checks++;
        if (dut.r_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d want=0", dut.r_state);
        end
        checks++;
        if (dut.r_hp[0] !== 32'd0 || dut.r_hp[1] !== 32'd0) begin
            failures++;
            $display("FAIL reset_hp got=%0d/%0d want=0/0", dut.r_hp[0], dut.r_hp[1]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_steady();
        volume = 3'd3;
        set_tones(32'd440, 32'd440);
        repeat (68) @(posedge clk);
        #1;
        checks++;
        if (dut.r_hp[0] !== 32'd113636 || dut.r_hp[1] !== 32'd113636) begin
            failures++;
            $display("FAIL steady_hp got=%0d/%0d want=113636", dut.r_hp[0], dut.r_hp[1]);
        end
        wait_fc(9'd505);
        push_frame(16'h1000, 16'hF000);
        push_frame(16'h1000, 16'hF000);
        wait_drain();
    endtask

    task automatic test_framing();
        int   bad_mclk = 0, bad_sck = 0, bad_lrck = 0, bad_sdin = 0;
        int   rm = 0, rs = 0, rl = 0, falls = 0;
        logic pm, ps, pl, pd;
        wait_fc(9'd0);
        pm = audio_mclk; ps = audio_sck; pl = audio_lrck; pd = audio_sdin;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (audio_mclk !== fcb[1]) bad_mclk++;
            if (audio_sck  !== fcb[3]) bad_sck++;
            if (audio_lrck !== fcb[8]) bad_lrck++;
            if (fcb[3:0] != 4'd0 && audio_sdin !== pd) bad_sdin++;
            if (!pm && audio_mclk) rm++;
            if (!ps && audio_sck)  rs++;
            if (!pl && audio_lrck) rl++;
            if (ps && !audio_sck)  falls++;
            if (audio_lrck !== pl) begin
                checks++;
                if (falls != 16) begin
                    failures++;
                    $display("FAIL half_sck_falls got=%0d want=16", falls);
                end
                falls = 0;
            end
            pm = audio_mclk; ps = audio_sck; pl = audio_lrck; pd = audio_sdin;
        end
        checks++;
        if (bad_mclk + bad_sck + bad_lrck != 0) begin
            failures++;
            $display("FAIL clock_phase got=%0d/%0d/%0d want=0", bad_mclk, bad_sck, bad_lrck);
        end
        checks++;
        if (rm != 512 || rs != 128 || rl != 4) begin
            failures++;
            $display("FAIL clock_rises got=%0d/%0d/%0d want=512/128/4", rm, rs, rl);
        end
        checks++;
        if (bad_sdin != 0) begin
            failures++;
            $display("FAIL sdin_change got=%0d want=0", bad_sdin);
        end
    endtask

    task automatic test_mute();
        wait_fc(9'd505);
        push_frame(16'h1000, 16'hF000);
        wait_fc(9'd200);
        mute = 1'b1;
        wait_fc(9'd505);
        push_frame(16'h0000, 16'h0000);
        wait_drain();
    endtask

    task automatic test_volume();
        wait_fc(9'd505);
        mute   = 1'b0;
        volume = 3'd7;
        push_frame(16'h4000, 16'hC000);
        wait_drain();
        volume = 3'd3;
    endtask

    task automatic test_silence();
        int   n;
        logic prev;
        set_tones(32'd50_000_000, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd113636) begin
            failures++;
            $display("FAIL silent_l_early got=%0d want=113636", dut.r_hp[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd0) begin
            failures++;
            $display("FAIL silent_l got=%0d want=0", dut.r_hp[0]);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[1] !== 32'd0) begin
            failures++;
            $display("FAIL silent_r got=%0d want=0", dut.r_hp[1]);
        end
        wait_fc(9'd505);
        push_frame(16'h0000, 16'h0000);
        push_frame(16'h0000, 16'h0000);
        wait_drain();
        set_tones(32'd19_999, 32'd0);
        repeat (33) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd0) begin
            failures++;
            $display("FAIL audible_early got=%0d want=0", dut.r_hp[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd2500) begin
            failures++;
            $display("FAIL audible_hp got=%0d want=2500", dut.r_hp[0]);
        end
        prev = dut.r_phase[0];
        n = 0;
        do begin @(posedge clk); #1; n++; end while (dut.r_phase[0] === prev && n < 6000);
        prev = dut.r_phase[0];
        n = 0;
        do begin @(posedge clk); #1; n++; end while (dut.r_phase[0] === prev && n < 6000);
        checks++;
        if (n != 2500) begin
            failures++;
            $display("FAIL phase_period got=%0d want=2500", n);
        end
    endtask

    task automatic test_simultaneous();
        set_tones(32'd262, 32'd262);
        repeat (80) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd190839 || dut.r_hp[1] !== 32'd190839) begin
            failures++;
            $display("FAIL base_hp got=%0d/%0d want=190839", dut.r_hp[0], dut.r_hp[1]);
        end
        set_tones(32'd524, 32'd330);
        repeat (33) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd190839) begin
            failures++;
            $display("FAIL simul_l_early got=%0d want=190839", dut.r_hp[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd95419) begin
            failures++;
            $display("FAIL simul_l got=%0d want=95419", dut.r_hp[0]);
        end
        repeat (33) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[1] !== 32'd190839) begin
            failures++;
            $display("FAIL simul_r_early got=%0d want=190839", dut.r_hp[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[1] !== 32'd151515) begin
            failures++;
            $display("FAIL simul_r got=%0d want=151515", dut.r_hp[1]);
        end
        set_tones(32'd440, 32'd330);
        repeat (10) @(posedge clk);
        @(negedge clk);
        toneL = 32'd330;
        repeat (24) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd113636) begin
            failures++;
            $display("FAIL rerun_first got=%0d want=113636", dut.r_hp[0]);
        end
        repeat (34) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd151515) begin
            failures++;
            $display("FAIL rerun_final got=%0d want=151515", dut.r_hp[0]);
        end
    endtask

    task automatic test_reset_midframe();
        set_tones(32'd440, 32'd440);
        repeat (100) @(posedge clk);
        wait_fc(9'd200);
        toneL = 32'd262;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0) begin
            failures++;
            $display("FAIL async_outputs got=%b want=0000",
                     {audio_mclk, audio_sck, audio_lrck, audio_sdin});
        end
        checks++;
        if (dut.r_state !== 2'd0 || dut.r_hp[0] !== 32'd0) begin
            failures++;
            $display("FAIL async_core got=%0d/%0d want=0/0", dut.r_state, dut.r_hp[0]);
        end
        toneL = 32'd440;
        @(negedge clk);
        rst = 1'b0;
        repeat (33) @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd0) begin
            failures++;
            $display("FAIL reload_early got=%0d want=0", dut.r_hp[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.r_hp[0] !== 32'd113636) begin
            failures++;
            $display("FAIL reload_hp got=%0d want=113636", dut.r_hp[0]);
        end
        checks++;
        if ({audio_mclk, audio_sck, audio_lrck} !== 3'b100) begin
            failures++;
            $display("FAIL fc_restart got=%b want=100", {audio_mclk, audio_sck, audio_lrck});
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_framing();
        test_mute();
        test_volume();
        test_silence();
        test_simultaneous();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
